stdp_column_ctrl: RTL and testbench
===================================

// Module: stdp_column_ctrl
// PURPOSE
// Parametrised temporal-coding column: N integrate-to-threshold neurons over M input spike-time channels,
// 1-winner-take-all lateral inhibition, on-chip STDP. Successor to the fixed-size layer: sequenced by FSM with
// start/done handshake, selectable learning rule, host weight load/read. Sits between spike encoder and next layer.
// PARAMETERS
// NUM_INPUTS   16  input channels M (>=2)
// NUM_NEURONS  4   neurons N (>=2)
// WBITS        3   weight width; WMAX = 2**WBITS-1
// TIME_BITS    3   spike-time width; window T = 2**TIME_BITS cycles
// THRESHOLD    8   firing threshold, compared against potential (WBITS+$clog2(NUM_INPUTS)+1 bits)
// LEARN_MODE   0   0 = binary (set WMAX / clear), 1 = incremental (+/-1, saturating)
// W_INIT       0   reset value of every weight
// PORTS
// clk         in   1                    clock
// rst         in   1                    asynchronous, active-high reset
// start       in   1                    begin a volley; accepted in IDLE only
// learn_en    in   1                    sampled with start; 1 = run LEARN phase
// in_valid    in   M                    per-channel spike present; sampled with start
// in_time     in   M*TIME_BITS          per-channel spike time; sampled with start
// wr_en       in   1                    host weight write; honoured in IDLE only
// wr_neuron   in   $clog2(N)            write neuron index
// wr_input    in   $clog2(M)            write channel index
// wr_data     in   WBITS                write value
// rd_neuron   in   $clog2(N)            read neuron index
// rd_input    in   $clog2(M)            read channel index
// rd_data     out  WBITS                weights[rd_neuron][rd_input], combinational
// busy        out  1                    high in INFER/LEARN/DONE
// done        out  1                    one-cycle pulse at end of volley
// out_valid   out  1                    a neuron fired this volley; held until next start
// out_winner  out  $clog2(N)            winning neuron; held until next start
// out_time    out  TIME_BITS            winner fire time; held until next start
// BEHAVIOUR
// - Reset: FSM=IDLE, t=0, potentials/fired mask=0, weights=W_INIT, busy=done=out_valid=0, out_winner=0, out_time=0.
// - IDLE: start=1 latches in_valid/in_time/learn_en, clears potentials, fired mask, out_*; t=0; -> INFER.
//   wr_en writes weight next edge. wr_en and start same cycle: write occurs, volley uses old weight.
// - INFER (exactly T cycles, t=0..T-1): pot[n] += sum of w[n][i] over valid i with in_time[i]==t.
//   Neuron n fires at t when updated pot[n] >= THRESHOLD and not already fired; sets fired[n].
//   First t with any fire: out_valid=1, out_winner=lowest firing index, out_time=t; later fires only update fired.
//   Potentials do not saturate (width sized for M*WMAX). At t==T-1 -> LEARN if learn_en else DONE.
// - LEARN (exactly N*M cycles): counter k visits n=k/M, i=k%M, one synapse per cycle, n-major, i-minor.
//   Let s = in_valid[i]. Rules:
//   winner (out_valid && n==out_winner): s ? (mode0 WMAX | mode1 +1 sat) : (mode0 0 | mode1 -1 sat at 0)
//   fired non-winner: s ? (mode0 0 | mode1 -1 sat) : unchanged
//   not fired: s ? +1 sat at WMAX : unchanged
//   Last k -> DONE.
// - DONE: done=1 for one cycle, -> IDLE. busy falls same edge done falls.
// - Latency start->done: T+1 cycles (learn_en=0) or T+N*M+1 cycles (learn_en=1), start cycle excluded.
// - start/wr_en while busy: ignored, no side effects. No fire in window: out_valid=0, out_winner=0, out_time=0;
//   LEARN still runs (all neurons treated not-fired).
// - rst mid-volley: immediate abort to reset state; weights revert to W_INIT.
// TESTING
// 1. Reset, read all weights -> rd_data==W_INIT; busy=0, done=0, out_valid=0.
// 2. Load w[2][*]=7 others 0, learn_en=0, ch0..1 valid at t=1 -> out_winner=2, out_time=1, done at T+1.
// 3. Neurons 1,3 cross threshold same t -> out_winner=1; fired mask {1,3}; learn mode0: w[3][spiked]=0, w[1][spiked]=7.
// 4. LEARN_MODE=1, winner weight 7 on spiked ch -> stays 7; non-spiked weight 0 -> stays 0 (saturation both ends).
// 5. No input valid, learn_en=1 -> out_valid=0, weights unchanged, done after T+N*M+1 cycles.
// 6. Assert rst at t=3 of INFER -> busy=0 immediately, weights W_INIT; start and wr_en while busy ignored.

Source files
------------

// File: rtl/stdp_column_ctrl.sv
// Temporal-coding column: N integrate-to-threshold neurons, 1-winner-take-all, on-chip STDP.
// Sequenced IDLE -> INFER (T cycles) -> optional LEARN (N*M cycles) -> DONE, with host weight access.
module stdp_column_ctrl #(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 4,
    parameter int WBITS       = 3,
    parameter int TIME_BITS   = 3,
    parameter int THRESHOLD   = 8,
    parameter int LEARN_MODE  = 0,
    parameter int W_INIT      = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             learn_en,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS*TIME_BITS-1:0]  in_time,
    input  logic                             wr_en,
    input  logic [$clog2(NUM_NEURONS)-1:0]   wr_neuron,
    input  logic [$clog2(NUM_INPUTS)-1:0]    wr_input,
    input  logic [WBITS-1:0]                 wr_data,
    input  logic [$clog2(NUM_NEURONS)-1:0]   rd_neuron,
    input  logic [$clog2(NUM_INPUTS)-1:0]    rd_input,
    output logic [WBITS-1:0]                 rd_data,
    output logic                             busy,
    output logic                             done,
    output logic                             out_valid,
    output logic [$clog2(NUM_NEURONS)-1:0]   out_winner,
    output logic [TIME_BITS-1:0]             out_time
);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int IW = $clog2(NUM_INPUTS);
    localparam int PW = WBITS + IW + 1;
    localparam logic [WBITS-1:0]     WMAX   = {WBITS{1'b1}};
    localparam logic [WBITS-1:0]     WINIT  = WBITS'(W_INIT);
    localparam logic [TIME_BITS-1:0] T_LAST = {TIME_BITS{1'b1}};
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INFER = 2'd1;
    localparam logic [1:0] S_LEARN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                    state_r, state_nx_s;
    logic [TIME_BITS-1:0]          t_r;
    logic [PW-1:0]                 pot_r    [NUM_NEURONS];
    logic [PW-1:0]                 pot_nx_s [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]        fired_r, fire_s;
    logic [NW-1:0]                 first_s;
    logic [NUM_INPUTS-1:0]         in_valid_r;
    logic [NUM_INPUTS*TIME_BITS-1:0] in_time_r;
    logic                          learn_en_r;
    logic [WBITS-1:0]              w_r    [NUM_NEURONS][NUM_INPUTS];
    logic [WBITS-1:0]              weff_s [NUM_NEURONS][NUM_INPUTS];
    logic                          ovr_r;
    logic [NW-1:0]                 ovr_n_r, lrn_n_r;
    logic [IW-1:0]                 ovr_i_r, lrn_i_r;
    logic [WBITS-1:0]              ovr_old_r, lrn_new_s;
    logic                          lrn_last_s;
    logic                          busy_r, done_r, out_valid_r;
    logic [NW-1:0]                 out_winner_r;
    logic [TIME_BITS-1:0]          out_time_r;

    function automatic logic [WBITS-1:0] sat_inc(input logic [WBITS-1:0] w);
        return (w == WMAX) ? WMAX : w + WBITS'(1'b1);
    endfunction

    function automatic logic [WBITS-1:0] sat_dec(input logic [WBITS-1:0] w);
        return (w == {WBITS{1'b0}}) ? {WBITS{1'b0}} : w - WBITS'(1'b1);
    endfunction

    function automatic logic [WBITS-1:0] next_weight(input logic [WBITS-1:0] w, input logic s,
                                                     input logic win, input logic fir);
        logic [WBITS-1:0] r;
        if (win) begin
            if (s) r = (LEARN_MODE == 0) ? WMAX : sat_inc(w);
            else   r = (LEARN_MODE == 0) ? {WBITS{1'b0}} : sat_dec(w);
        end else if (fir) begin
            if (s) r = (LEARN_MODE == 0) ? {WBITS{1'b0}} : sat_dec(w);
            else   r = w;
        end else begin
            if (s) r = sat_inc(w);
            else   r = w;
        end
        return r;
    endfunction

    assign rd_data    = w_r[rd_neuron][rd_input];
    assign busy       = busy_r;
    assign done       = done_r;
    assign out_valid  = out_valid_r;
    assign out_winner = out_winner_r;
    assign out_time   = out_time_r;

    // A host write accepted together with start must not affect this volley: substitute the old value.
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (ovr_r && (ovr_n_r == NW'(n)) && (ovr_i_r == IW'(i))) weff_s[n][i] = ovr_old_r;
                else                                                      weff_s[n][i] = w_r[n][i];
            end
        end
    end

    // Integrate the spikes arriving at the current time step and detect new fires.
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            pot_nx_s[n] = pot_r[n];
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (in_valid_r[i] && (in_time_r[i*TIME_BITS +: TIME_BITS] == t_r))
                    pot_nx_s[n] = pot_nx_s[n] + PW'(weff_s[n][i]);
                else
                    pot_nx_s[n] = pot_nx_s[n];
            end
            fire_s[n] = (pot_nx_s[n] >= PW'(THRESHOLD)) && !fired_r[n];
        end
        first_s = {NW{1'b0}};
        for (int n = NUM_NEURONS - 1; n >= 0; n--) begin
            if (fire_s[n]) first_s = NW'(n);
            else           first_s = first_s;
        end
    end

    // Learning update for the synapse visited this cycle, plus sequencer next state.
    always_comb begin
        lrn_new_s  = next_weight(weff_s[lrn_n_r][lrn_i_r], in_valid_r[lrn_i_r],
                                 out_valid_r && (lrn_n_r == out_winner_r), fired_r[lrn_n_r]);
        lrn_last_s = (lrn_n_r == NW'(NUM_NEURONS - 1)) && (lrn_i_r == IW'(NUM_INPUTS - 1));
        state_nx_s = state_r;
        case (state_r)
            S_IDLE:  if (start) state_nx_s = S_INFER; else state_nx_s = S_IDLE;
            S_INFER: if (t_r == T_LAST) state_nx_s = learn_en_r ? S_LEARN : S_DONE;
                     else state_nx_s = S_INFER;
            S_LEARN: if (lrn_last_s) state_nx_s = S_DONE; else state_nx_s = S_LEARN;
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Sequencer, volley capture, potentials and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            t_r          <= {TIME_BITS{1'b0}};
            for (int n = 0; n < NUM_NEURONS; n++) pot_r[n] <= {PW{1'b0}};
            fired_r      <= {NUM_NEURONS{1'b0}};
            in_valid_r   <= {NUM_INPUTS{1'b0}};
            in_time_r    <= {(NUM_INPUTS*TIME_BITS){1'b0}};
            learn_en_r   <= 1'b0;
            ovr_r        <= 1'b0;
            ovr_n_r      <= {NW{1'b0}};
            ovr_i_r      <= {IW{1'b0}};
            ovr_old_r    <= {WBITS{1'b0}};
            lrn_n_r      <= {NW{1'b0}};
            lrn_i_r      <= {IW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            out_winner_r <= {NW{1'b0}};
            out_time_r   <= {TIME_BITS{1'b0}};
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != S_IDLE);
            done_r  <= (state_nx_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    ovr_r <= start && wr_en;
                    if (start) begin
                        in_valid_r   <= in_valid;
                        in_time_r    <= in_time;
                        learn_en_r   <= learn_en;
                        ovr_n_r      <= wr_neuron;
                        ovr_i_r      <= wr_input;
                        ovr_old_r    <= w_r[wr_neuron][wr_input];
                        t_r          <= {TIME_BITS{1'b0}};
                        for (int n = 0; n < NUM_NEURONS; n++) pot_r[n] <= {PW{1'b0}};
                        fired_r      <= {NUM_NEURONS{1'b0}};
                        lrn_n_r      <= {NW{1'b0}};
                        lrn_i_r      <= {IW{1'b0}};
                        out_valid_r  <= 1'b0;
                        out_winner_r <= {NW{1'b0}};
                        out_time_r   <= {TIME_BITS{1'b0}};
                    end
                end
                S_INFER: begin
                    pot_r   <= pot_nx_s;
                    fired_r <= fired_r | fire_s;
                    t_r     <= t_r + TIME_BITS'(1'b1);
                    if (!out_valid_r && (|fire_s)) begin
                        out_valid_r  <= 1'b1;
                        out_winner_r <= first_s;
                        out_time_r   <= t_r;
                    end
                end
                S_LEARN: begin
                    if (lrn_i_r == IW'(NUM_INPUTS - 1)) begin
                        lrn_i_r <= {IW{1'b0}};
                        lrn_n_r <= lrn_n_r + NW'(1'b1);
                    end else begin
                        lrn_i_r <= lrn_i_r + IW'(1'b1);
                    end
                end
                S_DONE:  ;
                default: ;
            endcase
        end
    end

    // Weight store: host writes in IDLE, one STDP update per LEARN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                for (int i = 0; i < NUM_INPUTS; i++)
                    w_r[n][i] <= WINIT;
        end else if ((state_r == S_IDLE) && wr_en) begin
            w_r[wr_neuron][wr_input] <= wr_data;
        end else if (state_r == S_LEARN) begin
            w_r[lrn_n_r][lrn_i_r] <= lrn_new_s;
        end
    end
endmodule

// File: tb/tb_stdp_column_ctrl.sv
// Bench for stdp_column_ctrl: binary-rule and incremental-rule instances driven together,
// checked against a volley-level reference model of integration, winner selection and STDP.
module tb_stdp_column_ctrl;
    localparam int M = 16, N = 4, TB = 3, T = 8, TH = 8, WMX = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, learn_en = 1'b0, wr_en = 1'b0;
    logic [M-1:0]    in_valid = '0;
    logic [M*TB-1:0] in_time = '0;
    logic [1:0] wr_neuron = '0, rd_neuron = '0;
    logic [3:0] wr_input = '0, rd_input = '0;
    logic [2:0] wr_data = '0;
    logic [2:0] rd_data0, rd_data1, out_time0, out_time1;
    logic [1:0] out_winner0, out_winner1;
    logic busy0, busy1, done0, done1, out_valid0, out_valid1;

    stdp_column_ctrl #(.LEARN_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .learn_en(learn_en), .in_valid(in_valid),
        .in_time(in_time), .wr_en(wr_en), .wr_neuron(wr_neuron), .wr_input(wr_input),
        .wr_data(wr_data), .rd_neuron(rd_neuron), .rd_input(rd_input), .rd_data(rd_data0),
        .busy(busy0), .done(done0), .out_valid(out_valid0), .out_winner(out_winner0),
        .out_time(out_time0));

    stdp_column_ctrl #(.LEARN_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .learn_en(learn_en), .in_valid(in_valid),
        .in_time(in_time), .wr_en(wr_en), .wr_neuron(wr_neuron), .wr_input(wr_input),
        .wr_data(wr_data), .rd_neuron(rd_neuron), .rd_input(rd_input), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .out_valid(out_valid1), .out_winner(out_winner1),
        .out_time(out_time1));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int wm [2][N][M];
    logic [M-1:0] vv;
    int tt [M];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int v);
        for (int m = 0; m < 2; m++)
            for (int n = 0; n < N; n++)
                for (int i = 0; i < M; i++) wm[m][n][i] = v;
    endtask

    // Whole-volley reference: integrate over the window, pick the first/lowest fire, then apply STDP.
    task automatic model_volley(input int m, input bit learn, output bit ov, output int win, output int ot);
        int pot [N];
        bit fired [N];
        int w;
        bit s;
        ov = 0; win = 0; ot = 0;
        for (int n = 0; n < N; n++) begin pot[n] = 0; fired[n] = 0; end
        for (int t = 0; t < T; t++)
            for (int n = 0; n < N; n++) begin
                for (int i = 0; i < M; i++) if (vv[i] && tt[i] == t) pot[n] += wm[m][n][i];
                if (pot[n] >= TH && !fired[n]) begin
                    fired[n] = 1;
                    if (!ov) begin ov = 1; win = n; ot = t; end
                end
            end
        if (learn)
            for (int n = 0; n < N; n++)
                for (int i = 0; i < M; i++) begin
                    w = wm[m][n][i]; s = vv[i];
                    if (ov && n == win)
                        w = s ? (m == 0 ? WMX : (w < WMX ? w + 1 : WMX)) : (m == 0 ? 0 : (w > 0 ? w - 1 : 0));
                    else if (fired[n]) begin
                        if (s) w = (m == 0) ? 0 : (w > 0 ? w - 1 : 0);
                    end else if (s) w = (w < WMX) ? w + 1 : WMX;
                    wm[m][n][i] = w;
                end
    endtask

    task automatic wr_w(input int n, input int i, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_neuron = 2'(n); wr_input = 4'(i); wr_data = 3'(d);
        @(negedge clk);
        wr_en = 1'b0;
        wm[0][n][i] = d; wm[1][n][i] = d;
    endtask

    task automatic rd_chk(input string tag, input int m, input int n, input int i, input int exp);
        rd_neuron = 2'(n); rd_input = 4'(i);
        #1;
        chk(tag, (m == 0) ? rd_data0 : rd_data1, exp);
    endtask

    task automatic chk_weights(input string tag);
        for (int n = 0; n < N; n++)
            for (int i = 0; i < M; i++)
                for (int m = 0; m < 2; m++)
                    rd_chk($sformatf("%s_w%0d[%0d][%0d]", tag, m, n, i), m, n, i, wm[m][n][i]);
    endtask

    task automatic drive_volley(input bit learn, input bit wr_same, input int wn, input int wi, input int wd);
        @(negedge clk);
        start = 1'b1; learn_en = learn; in_valid = vv;
        for (int i = 0; i < M; i++) in_time[i*TB +: TB] = 3'(tt[i]);
        wr_en = wr_same; wr_neuron = 2'(wn); wr_input = 4'(wi); wr_data = 3'(wd);
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
    endtask

    // One volley: model prediction, stray start/write while busy, latency, results, weights.
    task automatic volley(input string tag, input bit learn, input bit wr_same, input int wn, input int wi, input int wd);
        bit ov [2];
        int win [2];
        int ot [2];
        int cyc, exp_lat;
        for (int m = 0; m < 2; m++) model_volley(m, learn, ov[m], win[m], ot[m]);
        if (wr_same) begin wm[0][wn][wi] = wd; wm[1][wn][wi] = wd; end
        exp_lat = learn ? T + N * M + 1 : T + 1;
        drive_volley(learn, wr_same, wn, wi, wd);
        cyc = 1;
        chk({tag, "_busy0"}, busy0, 1);
        chk({tag, "_busy1"}, busy1, 1);
        while (!done0 && cyc < exp_lat + 20) begin
            if (cyc == 2) begin
                start = 1'b1; wr_en = 1'b1; in_valid = ~vv; learn_en = ~learn;
                wr_neuron = 2'($urandom); wr_input = 4'($urandom); wr_data = 3'($urandom);
            end else begin
                start = 1'b0; wr_en = 1'b0; in_valid = vv; learn_en = learn;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; wr_en = 1'b0;
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_done1"}, done1, 1);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s_m%0d_valid", tag, m), (m == 0) ? out_valid0 : out_valid1, ov[m]);
            chk($sformatf("%s_m%0d_winner", tag, m), (m == 0) ? out_winner0 : out_winner1, win[m]);
            chk($sformatf("%s_m%0d_time", tag, m), (m == 0) ? out_time0 : out_time1, ot[m]);
        end
        @(negedge clk);
        chk({tag, "_done_pulse0"}, done0, 0);
        chk({tag, "_busy_end0"}, busy0, 0);
        chk({tag, "_busy_end1"}, busy1, 0);
        chk_weights(tag);
    endtask

    initial begin
        for (int i = 0; i < M; i++) tt[i] = 0;
        vv = '0;
        model_clear(0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("t1_busy0", busy0, 0); chk("t1_busy1", busy1, 0);
        chk("t1_done0", done0, 0); chk("t1_valid0", out_valid0, 0); chk("t1_valid1", out_valid1, 0);
        chk("t1_winner0", out_winner0, 0); chk("t1_time0", out_time0, 0);
        chk_weights("t1");

        // neuron 2 strong, channels 0 and 1 spike at t=1
        for (int i = 0; i < M; i++) wr_w(2, i, 7);
        vv = 16'h0003;
        for (int i = 0; i < M; i++) tt[i] = $urandom_range(0, 7);
        tt[0] = 1; tt[1] = 1;
        volley("t2", 1'b0, 1'b0, 0, 0, 0);
        chk("t2_winner_const", out_winner0, 2);
        chk("t2_time_const", out_time0, 1);

        // neurons 1 and 3 cross together: lowest index wins, both learn
        for (int i = 0; i < M; i++) begin wr_w(2, i, 0); wr_w(1, i, 4); wr_w(3, i, 4); end
        tt[0] = 2; tt[1] = 2;
        volley("t3", 1'b1, 1'b0, 0, 0, 0);
        chk("t3_winner_const", out_winner0, 1);
        rd_chk("t3_w3_spiked", 0, 3, 0, 0);
        rd_chk("t3_w1_spiked", 0, 1, 0, 7);

        // saturation of the incremental rule at both ends
        for (int n = 0; n < N; n++) for (int i = 0; i < M; i++) wr_w(n, i, 0);
        wr_w(0, 0, 7); wr_w(0, 2, 7);
        vv = 16'h0005; tt[0] = 0; tt[2] = 0;
        volley("t4", 1'b1, 1'b0, 0, 0, 0);
        rd_chk("t4_sat_hi", 1, 0, 0, 7);
        rd_chk("t4_sat_lo", 1, 0, 1, 0);

        // silent window with learning
        vv = '0;
        volley("t5", 1'b1, 1'b0, 0, 0, 0);
        chk("t5_novalid_const", out_valid0, 0);

        // write in the start cycle: volley still sees the old weight (neuron 0 fires only with it)
        vv = 16'h0005; tt[0] = 0; tt[2] = 0;
        volley("t7", 1'b0, 1'b1, 0, 0, 0);
        chk("t7_old_weight_valid", out_valid0, 1);
        rd_chk("t7_new_weight", 0, 0, 0, 0);

        // randomized volleys
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < N; n++) for (int i = 0; i < M; i++) wr_w(n, i, $urandom_range(0, 7));
            vv = 16'($urandom);
            for (int i = 0; i < M; i++) tt[i] = $urandom_range(0, 7);
            volley($sformatf("r%0d", r), 1'($urandom), 1'b0, 0, 0, 0);
        end

        // reset at t=3 of INFER aborts the volley and restores initial weights
        vv = 16'hffff;
        drive_volley(1'b1, 1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("t6_busy_before", busy0, 1);
        rst = 1'b1;
        #1;
        model_clear(0);
        chk("t6_busy0", busy0, 0); chk("t6_busy1", busy1, 0);
        chk("t6_done0", done0, 0); chk("t6_valid0", out_valid0, 0);
        chk_weights("t6");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_idle_after", busy0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
